// File: rtl/reg_bank_arb_pkg.sv
// reg_bank_arb_pkg: state encoding, default bank geometry and address range check
// shared by reg_bank_arbiter and its round-robin sub-arbiter.
package reg_bank_arb_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_e;
  localparam int DEF_NUM_REGS = 14;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 16;
  function automatic logic addr_in_range(input int addr, input int num_regs = DEF_NUM_REGS);
    return addr < num_regs;
  endfunction
endpackage

// File: rtl/reg_bank_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant; the search starts one past ptr,
// so the requester at ptr has lowest priority.
module rr_arbiter #(
  parameter int N = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);
  logic [IW-1:0] k;
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    k = '0;
    // scan lowest priority first so the highest-priority hit is written last
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(ptr) + i) % N);
      if (req[k]) begin
        gnt_idx = k;
        gnt_any = 1'b1;
      end
    end
    gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
  end
endmodule

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin single-outstanding access from NUM_REQ requesters to a
// register bank; optional counters under REG_BANK_ARB_STATS_EN.
module reg_bank_arbiter
  import reg_bank_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic                      bank_write_en,
  output logic                      bank_read_en,
  output logic [ADDR_W-1:0]         bank_addr,
  output logic [DATA_W-1:0]         bank_data_in,
  input  logic [DATA_W-1:0]         bank_data_out
`ifdef REG_BANK_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     stat_grants,
  output logic [15:0]               stat_errors,
  input  logic                      stat_clr
`endif
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, own_q, own_d;
  logic we_q, we_d, err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0] gnt_idx;
  logic gnt_any, g_in_range;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .req(req_valid),
    .ptr(ptr_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_any(gnt_any)
  );
  assign g_addr = req_addr[gnt_idx*ADDR_W +: ADDR_W];
  assign g_wdata = req_wdata[gnt_idx*DATA_W +: DATA_W];
  assign g_in_range = addr_in_range(int'(g_addr), NUM_REGS);
  assign bank_addr = addr_q;
  assign bank_data_in = wdata_q;
  assign resp_rdata = rdata_q;
  assign resp_err = err_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    own_d = own_q;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    err_d = err_q;
    rdata_d = rdata_q;
    req_ready = '0;
    bank_write_en = 1'b0;
    bank_read_en = 1'b0;
    resp_valid = '0;
    case (state_q)
      IDLE: begin
        // ready is gated by reset so nothing can be accepted while rst is low
        req_ready = rst ? gnt : '0;
        if (gnt_any) begin
          ptr_d = gnt_idx;
          own_d = gnt_idx;
          we_d = req_we[gnt_idx];
          err_d = !g_in_range;
          rdata_d = '0;
          addr_d = g_in_range ? g_addr : addr_q;
          wdata_d = g_in_range ? g_wdata : wdata_q;
          state_d = g_in_range ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        bank_write_en = we_q;
        bank_read_en = !we_q;
        state_d = we_q ? RESP : CAPTURE;
      end
      CAPTURE: begin
        rdata_d = bank_data_out;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = NUM_REQ'(1) << own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q <= IW'(NUM_REQ - 1);
      own_q <= '0;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      own_q <= own_d;
      we_q <= we_d;
      err_q <= err_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
`ifdef REG_BANK_ARB_STATS_EN
  logic [15:0] grant_cnt_q [NUM_REQ];
  logic [15:0] grant_cnt_d [NUM_REQ];
  logic [15:0] err_cnt_q, err_cnt_d;
  logic accept;
  assign accept = (state_q == IDLE) && gnt_any && rst;
  assign stat_errors = err_cnt_q;
  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_cnt_d[i] = stat_clr ? 16'd0 :
                       (accept && gnt_idx == IW'(i) && grant_cnt_q[i] != 16'hFFFF) ? grant_cnt_q[i] + 16'd1 :
                       grant_cnt_q[i];
      stat_grants[i*16 +: 16] = grant_cnt_q[i];
    end
    err_cnt_d = stat_clr ? 16'd0 :
                (accept && !g_in_range && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 :
                err_cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= '0;
      err_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_q[i] <= grant_cnt_d[i];
      err_cnt_q <= err_cnt_d;
    end
  end
`endif
endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb_reg_bank_arbiter: directed vector table plus hand-written reset-abort and
// valid-drop sequences against a behavioural register bank.
module tb_reg_bank_arbiter;
  localparam int NR = 2;
  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [3:0]  addr0;
    logic [3:0]  addr1;
    logic [15:0] wd0;
    logic [15:0] wd1;
    logic        owner;
    logic [2:0]  lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NR-1:0] req_valid = '0, req_we = '0;
  logic [NR-1:0] req_ready, resp_valid;
  logic [NR*4-1:0] req_addr = '0;
  logic [NR*16-1:0] req_wdata = '0;
  logic [15:0] resp_rdata, bank_data_in, bank_data_out;
  logic resp_err, bank_write_en, bank_read_en;
  logic [3:0] bank_addr;
  logic [15:0] mem [16];
  int n_cmp = 0;
  int n_fail = 0;
  vec_t vecs [15];
`ifdef REG_BANK_ARB_STATS_EN
  logic [NR*16-1:0] stat_grants;
  logic [15:0] stat_errors;
  logic stat_clr = 1'b0;
`endif
  reg_bank_arbiter #(.NUM_REQ(NR)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .bank_write_en(bank_write_en),
    .bank_read_en(bank_read_en),
    .bank_addr(bank_addr),
    .bank_data_in(bank_data_in),
    .bank_data_out(bank_data_out)
`ifdef REG_BANK_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_errors(stat_errors),
    .stat_clr(stat_clr)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bank_write_en) mem[bank_addr] <= bank_data_in;
    if (bank_read_en) bank_data_out <= mem[bank_addr];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic run_vec(input vec_t v);
    int lat, strobe_at;
    logic [1:0] kind;
    logic [3:0] s_addr;
    logic [15:0] s_din;
    lat = 0;
    strobe_at = 0;
    kind = 2'b00;
    s_addr = '0;
    s_din = '0;
    @(negedge clk);
    req_valid = v.valid;
    req_we = v.we;
    req_addr = {v.addr1, v.addr0};
    req_wdata = {v.wd1, v.wd0};
    #1;
    for (int i = 0; i < 8 && req_ready == '0; i++) begin
      @(negedge clk);
      #1;
    end
    chk("ready_owner", req_ready, 2'b01 << v.owner);
    @(posedge clk);
    #1 req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (bank_write_en | bank_read_en) begin
        strobe_at = k;
        kind = {bank_write_en, bank_read_en};
        s_addr = bank_addr;
        s_din = bank_data_in;
      end
      if (resp_valid != '0) begin
        lat = k;
        chk("resp_owner", resp_valid, 2'b01 << v.owner);
        chk("resp_err", resp_err, v.err);
        chk("resp_rdata", resp_rdata, v.rdata);
        break;
      end
    end
    chk("resp_latency", lat, v.lat);
    chk("strobe_cycle", strobe_at, v.err ? 0 : 1);
    if (!v.err) begin
      chk("strobe_kind", kind, v.we[v.owner] ? 2'b10 : 2'b01);
      chk("bank_addr", s_addr, v.owner ? v.addr1 : v.addr0);
      if (v.we[v.owner]) chk("bank_data_in", s_din, v.owner ? v.wd1 : v.wd0);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0]  = '{valid:2'b01, we:2'b01, addr0:4'd3, addr1:4'd0, wd0:16'h1234, wd1:16'h0, owner:1'b0, lat:3'd2, err:1'b0, rdata:16'h0};
    vecs[1]  = '{valid:2'b01, we:2'b00, addr0:4'd3, addr1:4'd0, wd0:16'h0, wd1:16'h0, owner:1'b0, lat:3'd3, err:1'b0, rdata:16'h1234};
    vecs[2]  = '{valid:2'b10, we:2'b10, addr0:4'd0, addr1:4'd5, wd0:16'h0, wd1:16'hBEEF, owner:1'b1, lat:3'd2, err:1'b0, rdata:16'h0};
    for (int i = 3; i < 9; i++)
      vecs[i] = '{valid:2'b11, we:2'b00, addr0:4'd3, addr1:4'd5, wd0:16'h0, wd1:16'h0, owner:i[0] ? 1'b0 : 1'b1, lat:3'd3, err:1'b0, rdata:i[0] ? 16'h1234 : 16'hBEEF};
    vecs[9]  = '{valid:2'b10, we:2'b00, addr0:4'd0, addr1:4'd14, wd0:16'h0, wd1:16'h0, owner:1'b1, lat:3'd1, err:1'b1, rdata:16'h0};
    vecs[10] = '{valid:2'b10, we:2'b10, addr0:4'd0, addr1:4'd15, wd0:16'h0, wd1:16'hFFFF, owner:1'b1, lat:3'd1, err:1'b1, rdata:16'h0};
    vecs[11] = '{valid:2'b10, we:2'b10, addr0:4'd0, addr1:4'd13, wd0:16'h0, wd1:16'h0D0D, owner:1'b1, lat:3'd2, err:1'b0, rdata:16'h0};
    vecs[12] = '{valid:2'b10, we:2'b00, addr0:4'd0, addr1:4'd13, wd0:16'h0, wd1:16'h0, owner:1'b1, lat:3'd3, err:1'b0, rdata:16'h0D0D};
    vecs[13] = '{valid:2'b01, we:2'b01, addr0:4'd0, addr1:4'd0, wd0:16'hAAAA, wd1:16'h0, owner:1'b0, lat:3'd2, err:1'b0, rdata:16'h0};
    vecs[14] = '{valid:2'b11, we:2'b00, addr0:4'd0, addr1:4'd0, wd0:16'h0, wd1:16'h0, owner:1'b0, lat:3'd3, err:1'b0, rdata:16'hAAAA};
    req_valid = 2'b11;
    #2 rst = 1'b0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_strobes", {bank_write_en, bank_read_en}, 0);
    chk("rst_rdata_err", {resp_rdata, resp_err}, 0);
    chk("rst_bank_bus", {bank_addr, bank_data_in}, 0);
    repeat (2) @(negedge clk);
    req_valid = '0;
    rst = 1'b1;
    for (int i = 0; i < 14; i++) run_vec(vecs[i]);
    @(negedge clk);
    req_valid = 2'b01;
    req_we = 2'b01;
    req_addr = '0;
    req_wdata = {16'h0, 16'h5555};
    #1 chk("t4_ready", req_ready, 2'b01);
    @(posedge clk);
    #1 req_valid = '0;
    chk("t4_issue_we", bank_write_en, 1);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b11;
    req_we = '0;
    #1;
    chk("t4_abort_strobes", {bank_write_en, bank_read_en}, 0);
    chk("t4_abort_resp", {resp_valid, resp_err, resp_rdata}, 0);
    chk("t4_abort_bus", {bank_addr, bank_data_in}, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t4_rst_hold", {req_ready, resp_valid, bank_write_en, bank_read_en}, 0);
    end
    req_valid = '0;
    rst = 1'b1;
    run_vec(vecs[14]);
    @(negedge clk);
    req_valid = 2'b10;
    req_we = '0;
    req_addr = {4'd13, 4'd3};
    #1 chk("t5_first_ready", req_ready, 2'b10);
    @(posedge clk);
    #1 req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t5_busy_ready", req_ready, 0);
      if (resp_valid != '0) break;
    end
    chk("t5_first_resp", resp_valid, 2'b10);
    req_valid = 2'b10;
    #1 chk("t5_resp_ready", req_ready, 0);
    run_vec('{valid:2'b10, we:2'b00, addr0:4'd3, addr1:4'd13, wd0:16'h0, wd1:16'h0, owner:1'b1, lat:3'd3, err:1'b0, rdata:16'h0D0D});
    @(negedge clk);
    chk("t5_no_spurious", {req_ready, resp_valid}, 0);
`ifdef REG_BANK_ARB_STATS_EN
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    run_vec('{valid:2'b01, we:2'b01, addr0:4'd1, addr1:4'd0, wd0:16'h1111, wd1:16'h0, owner:1'b0, lat:3'd2, err:1'b0, rdata:16'h0});
    run_vec('{valid:2'b10, we:2'b10, addr0:4'd0, addr1:4'd2, wd0:16'h0, wd1:16'h2222, owner:1'b1, lat:3'd2, err:1'b0, rdata:16'h0});
    run_vec('{valid:2'b01, we:2'b00, addr0:4'd14, addr1:4'd0, wd0:16'h0, wd1:16'h0, owner:1'b0, lat:3'd1, err:1'b1, rdata:16'h0});
    run_vec('{valid:2'b10, we:2'b00, addr0:4'd0, addr1:4'd2, wd0:16'h0, wd1:16'h0, owner:1'b1, lat:3'd3, err:1'b0, rdata:16'h2222});
    run_vec('{valid:2'b01, we:2'b01, addr0:4'd1, addr1:4'd0, wd0:16'h3333, wd1:16'h0, owner:1'b0, lat:3'd2, err:1'b0, rdata:16'h0});
    chk("stat_grants", stat_grants, {16'd2, 16'd3});
    chk("stat_errors", stat_errors, 1);
    @(negedge clk);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    chk("stat_grants_clr", stat_grants, 0);
    chk("stat_errors_clr", stat_errors, 0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
